cpu_core_p: RTL

Parametrised multi-cycle CPU core, successor to the fixed 16-bit course-design CPU. It merges control unit, datapath, PC and LED register into one block with a generic data width. It uses one shared memory port with a req/ack handshake, so instruction and data RAM can be any latency, and it adds a conditional branch, a zero flag, run/stall control and a halt state. It sits between the board top (switches, LEDs) and the instruction/data memory.

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/cpu_alu.sv | 30 +++
 rtl/cpu_core_p.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_core_p multi-cycle core:
// opcodes, FSM state encoding and instruction field positions.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_MVI = 4'h7;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_OUT = 4'hC;
    localparam logic [3:0] OP_ILD = 4'hD;
    localparam logic [3:0] OP_ILE = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_MEM   = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        EXEC  = ST_EXEC,
        MEM   = ST_MEM,
        HALT  = ST_HALT
    } state_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: op selects ADD/SUB/AND/OR/XOR/SHL, every other
// opcode passes b through (used by MVI and LD). Ports: op, a, b -> result, zero.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        result = b;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL:  result = a << 1;
            default: result = b;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/cpu_core_p.sv
// Multi-cycle CPU core with one shared req/ack memory port, 4 registers,
// zero flag, LED register and halt. Ports: clk, rst (sync, low), run,
// mem_req/we/addr/wdata/rdata/ack, pc_out, led, halted, illegal.
module cpu_core_p
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int LED_W  = 8,
    parameter int RST_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc_out,
    output logic [LED_W-1:0]  led,
    output logic              halted,
    output logic              illegal
);

    // Instructions are always 16 bits; narrow data words are zero-extended.
    localparam int IW = (DATA_W > 16) ? DATA_W : 16;

    state_t            state;
    logic [15:0]       ir;
    logic [DATA_W-1:0] regs [4];
    logic              z;
    logic [ADDR_W-1:0] pc;

    logic [IW-1:0]     rdata_ext;
    logic [15:0]       instr;
    logic [3:0]        op;
    logic [1:0]        rd;
    logic [1:0]        rs;
    logic [7:0]        imm;
    logic [ADDR_W-1:0] imm_addr;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_y;
    logic              alu_z;

    assign rdata_ext = IW'(mem_rdata);
    assign instr     = rdata_ext[15:0];

    assign op       = ir[OP_MSB:OP_LSB];
    assign rd       = ir[RD_MSB:RD_LSB];
    assign rs       = ir[RS_MSB:RS_LSB];
    assign imm      = ir[IMM_MSB:IMM_LSB];
    assign imm_addr = imm[ADDR_W-1:0];

    // In MEM the only ALU user is LD, which passes read data through.
    assign alu_b = (state == MEM)    ? mem_rdata :
                   (op == OP_MVI)    ? DATA_W'(imm) :
                                       regs[rs];

    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (op),
        .a      (regs[rd]),
        .b      (alu_b),
        .result (alu_y),
        .zero   (alu_z)
    );

    assign pc_out  = pc;
    assign halted  = (state == HALT);
    assign illegal = (state == EXEC) && (op == OP_ILD || op == OP_ILE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            ir        <= '0;
            z         <= 1'b0;
            pc        <= ADDR_W'(RST_PC);
            led       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (run) state <= FETCH;
                end
                FETCH: begin
                    // First cycle launches the request, then wait for ack.
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        ir      <= instr;
                        pc      <= pc + 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR,
                        OP_XOR, OP_SHL, OP_MVI: begin
                            regs[rd] <= alu_y;
                            z        <= alu_z;
                        end
                        OP_JMP: pc <= imm_addr;
                        OP_JZ:  if (z) pc <= imm_addr;
                        OP_OUT: led <= regs[rd][LED_W-1:0];
                        default: ;
                    endcase
                    if (op == OP_LD || op == OP_ST) state <= MEM;
                    else if (op == OP_HLT)           state <= HALT;
                    else                             state <= run ? FETCH : IDLE;
                end
                MEM: begin
                    if (!mem_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= (op == OP_ST);
                        mem_addr  <= imm_addr;
                        mem_wdata <= regs[rd];
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (op == OP_LD) begin
                            regs[rd] <= alu_y;
                            z        <= alu_z;
                        end
                        state <= run ? FETCH : IDLE;
                    end
                end
                HALT: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
